// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer and its neighbours.
// Holds the ROB row bundle and the ROB sizing constants.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH    = 16;
  localparam int ROB_ALLOC_W  = 2;
  localparam int ROB_NUM_FU   = 3;
  localparam int ROB_RETIRE_W = 2;

  typedef logic [3:0]  rob_idx;
  typedef logic [5:0]  p_reg;
  typedef logic [31:0] word;

  typedef struct packed {
    logic   valid;
    logic   complete;
    rob_idx ROBNumber;
    p_reg   PRegAddrDst;
    p_reg   OldPRegAddrDst;
    logic   RegWrite;
    logic   MemWrite;
    word    data;
  } rob_row_struct;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / FU / retire bundle of the reorder buffer.
// The master side is dispatch and the FUs; the slave is the ROB.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  rob_row_struct i_alloc_rows        [ROB_ALLOC_W];
  rob_row_struct i_fu_results        [ROB_NUM_FU];
  rob_row_struct o_complete_rob_rows [ROB_NUM_FU];
  rob_row_struct o_retire_rows       [ROB_RETIRE_W];
  logic [4:0]    o_count;
  logic          o_full;
  logic          o_ready;
  logic          o_overflow;
  logic          o_seq_err;

  modport master (
    output i_alloc_rows, i_fu_results,
    input  o_complete_rob_rows, o_retire_rows,
    input  o_count, o_full, o_ready,
    input  o_overflow, o_seq_err
  );

  modport slave (
    input  i_alloc_rows, i_fu_results,
    output o_complete_rob_rows, o_retire_rows,
    output o_count, o_full, o_ready,
    output o_overflow, o_seq_err
  );

endinterface

// File: rtl/rob_retire_select.sv
// Picks which of the two oldest ROB entries retire this cycle.
// Only one store may commit per cycle.
module rob_retire_select (
  input  logic       i_h0_valid,
  input  logic       i_h0_complete,
  input  logic       i_h0_mem,
  input  logic       i_h1_valid,
  input  logic       i_h1_complete,
  input  logic       i_h1_mem,
  output logic [1:0] o_mask
);

  // lane1 only follows lane0, and never as a second store
  always_comb begin
    o_mask    = '0;
    o_mask[0] = i_h0_valid & i_h0_complete;
    o_mask[1] = o_mask[0] & i_h1_valid & i_h1_complete
              & ~(i_h0_mem & i_h1_mem);
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: 2-wide alloc, 3 FU completions,
// registered wakeup broadcast and 2-wide in-order retire.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  reorder_buffer_if.slave  bus
);

  localparam int DEPTH    = ROB_DEPTH;
  localparam int ALLOC_W  = ROB_ALLOC_W;
  localparam int NUM_FU   = ROB_NUM_FU;
  localparam int RETIRE_W = ROB_RETIRE_W;

  rob_row_struct ent_q [DEPTH];
  rob_row_struct ent_d [DEPTH];
  rob_row_struct bc_q  [NUM_FU];
  rob_row_struct bc_d  [NUM_FU];
  rob_row_struct rt_q  [RETIRE_W];
  rob_row_struct rt_d  [RETIRE_W];

  rob_idx     head_q, head_d;
  rob_idx     tail_q, tail_d;
  logic [4:0] count_q, count_d;
  logic       full_q, full_d;
  logic       ready_q, ready_d;
  logic       ovf_q, ovf_d;
  logic       seq_q, seq_d;

  rob_idx     head1;
  logic [1:0] ret_mask;
  logic       unused_in;

  assign head1 = head_q + 4'd1;

  rob_retire_select u_sel (
    .i_h0_valid    (ent_q[head_q].valid),
    .i_h0_complete (ent_q[head_q].complete),
    .i_h0_mem      (ent_q[head_q].MemWrite),
    .i_h1_valid    (ent_q[head1].valid),
    .i_h1_complete (ent_q[head1].complete),
    .i_h1_mem      (ent_q[head1].MemWrite),
    .o_mask        (ret_mask)
  );

  // retire, complete and allocate against start-of-cycle state
  always_comb begin
    logic [4:0]        free;
    logic [4:0]        acc;
    logic [1:0]        nret;
    logic [NUM_FU-1:0] take;
    rob_idx            widx;
    rob_idx            r;
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    ovf_d  = ovf_q;
    seq_d  = seq_q;
    free   = 5'(DEPTH) - count_q;
    acc    = '0;
    nret   = '0;
    take   = '0;
    widx   = '0;
    r      = '0;
    for (int f = 0; f < NUM_FU; f++) bc_d[f] = '0;
    for (int l = 0; l < RETIRE_W; l++) rt_d[l] = '0;

    if (ret_mask[0]) begin
      rt_d[0]       = ent_q[head_q];
      ent_d[head_q] = '0;
      nret          = 2'd1;
    end
    if (ret_mask[1]) begin
      rt_d[1]      = ent_q[head1];
      ent_d[head1] = '0;
      nret         = 2'd2;
    end
    head_d = head_q + {2'b0, nret};

    for (int f = 0; f < NUM_FU; f++) begin
      r       = bus.i_fu_results[f].ROBNumber;
      take[f] = bus.i_fu_results[f].valid
              & ent_q[r].valid & ~ent_q[r].complete;
      for (int g = 0; g < f; g++)
        if (take[g] && bus.i_fu_results[g].ROBNumber == r)
          take[f] = 1'b0;
      if (take[f]) begin
        ent_d[r].complete = 1'b1;
        ent_d[r].data     = bus.i_fu_results[f].data;
        bc_d[f]           = ent_d[r];
      end
    end

    for (int l = 0; l < ALLOC_W; l++) begin
      if (bus.i_alloc_rows[l].valid) begin
        if (acc < free) begin
          widx = tail_q + acc[3:0];
          if (bus.i_alloc_rows[l].ROBNumber != widx)
            seq_d = 1'b1;
          ent_d[widx]           = bus.i_alloc_rows[l];
          ent_d[widx].valid     = 1'b1;
          ent_d[widx].complete  = 1'b0;
          ent_d[widx].data      = '0;
          ent_d[widx].ROBNumber = widx;
          acc = acc + 5'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
    tail_d  = tail_q + acc[3:0];
    count_d = count_q + acc - {3'b0, nret};
    full_d  = (count_d == 5'(DEPTH));
    ready_d = (5'(DEPTH) - count_d) >= 5'(ALLOC_W);
  end

  // fold input bits the ROB never looks at
  always_comb begin
    unused_in = 1'b0;
    for (int f = 0; f < NUM_FU; f++)
      unused_in = unused_in ^ (^bus.i_fu_results[f]);
    for (int l = 0; l < ALLOC_W; l++)
      unused_in = unused_in ^ (^bus.i_alloc_rows[l]);
  end

  // state and registered outputs, synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      for (int f = 0; f < NUM_FU; f++) bc_q[f] <= '0;
      for (int l = 0; l < RETIRE_W; l++) rt_q[l] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      ovf_q   <= 1'b0;
      seq_q   <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      bc_q    <= bc_d;
      rt_q    <= rt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      seq_q   <= seq_d;
    end
  end

  assign bus.o_complete_rob_rows = bc_q;
  assign bus.o_retire_rows       = rt_q;
  assign bus.o_count             = count_q;
  assign bus.o_full              = full_q;
  assign bus.o_ready             = ready_q;
  assign bus.o_overflow          = ovf_q;
  assign bus.o_seq_err           = seq_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer.
// Scoreboard queues hold expected retires and broadcasts.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lane;
    int idx;
  } bc_exp_t;

  int      n_chk = 0;
  int      n_err = 0;
  int      ret_q [$];
  bc_exp_t bcx_q [$];
  p_reg    m_dst  [ROB_DEPTH];
  word     m_data [ROB_DEPTH];
  logic    m_mem  [ROB_DEPTH];

  task automatic clr_in();
    for (int l = 0; l < ROB_ALLOC_W; l++) bus.i_alloc_rows[l] = '0;
    for (int f = 0; f < ROB_NUM_FU; f++) bus.i_fu_results[f] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input int lane, input int rn,
                           input int dst, input bit mem);
    rob_row_struct row;
    row                = '0;
    row.valid          = 1'b1;
    row.complete       = 1'b1;
    row.ROBNumber      = rob_idx'(rn);
    row.PRegAddrDst    = p_reg'(dst);
    row.OldPRegAddrDst = p_reg'(dst + 32);
    row.RegWrite       = ~mem;
    row.MemWrite       = mem;
    row.data           = 32'hDEAD_BEEF;
    bus.i_alloc_rows[lane] = row;
  endtask

  task automatic alloc(input int lane, input int rn,
                       input int dst, input bit mem);
    set_alloc(lane, rn, dst, mem);
    m_dst[rn]  = p_reg'(dst);
    m_mem[rn]  = mem;
    m_data[rn] = '0;
    ret_q.push_back(rn);
  endtask

  task automatic set_fu(input int lane, input int rn, input int data);
    rob_row_struct row;
    row           = '0;
    row.valid     = 1'b1;
    row.ROBNumber = rob_idx'(rn);
    row.data      = word'(data);
    bus.i_fu_results[lane] = row;
  endtask

  task automatic fu(input int lane, input int rn, input int data);
    bc_exp_t e;
    set_fu(lane, rn, data);
    m_data[rn] = word'(data);
    e.lane = lane;
    e.idx  = rn;
    bcx_q.push_back(e);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clr_in();
    tick();
    rst = 1'b0;
    ret_q.delete();
    bcx_q.delete();
  endtask

  task automatic wait_empty(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_count == 5'd0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // scoreboard: every valid retire/broadcast lane pops an expectation
  always @(negedge clk) begin : mon
    int      ix;
    bc_exp_t e;
    for (int l = 0; l < ROB_RETIRE_W; l++) begin
      if (bus.o_retire_rows[l].valid) begin
        n_chk++;
        if (ret_q.size() == 0) begin
          n_err++;
          $display("FAIL retire_extra lane=%0d got rob=%0d exp none",
                   l, bus.o_retire_rows[l].ROBNumber);
        end else begin
          ix = ret_q.pop_front();
          if (bus.o_retire_rows[l].ROBNumber !== rob_idx'(ix) ||
              bus.o_retire_rows[l].PRegAddrDst !== m_dst[ix] ||
              bus.o_retire_rows[l].data !== m_data[ix] ||
              bus.o_retire_rows[l].MemWrite !== m_mem[ix] ||
              bus.o_retire_rows[l].complete !== 1'b1) begin
            n_err++;
            $display("FAIL retire_row lane=%0d got rob=%0d dst=%0d data=%0h exp rob=%0d dst=%0d data=%0h",
                     l, bus.o_retire_rows[l].ROBNumber,
                     bus.o_retire_rows[l].PRegAddrDst,
                     bus.o_retire_rows[l].data,
                     ix, m_dst[ix], m_data[ix]);
          end
        end
      end
    end
    for (int f = 0; f < ROB_NUM_FU; f++) begin
      if (bus.o_complete_rob_rows[f].valid) begin
        n_chk++;
        if (bcx_q.size() == 0) begin
          n_err++;
          $display("FAIL bcast_extra lane=%0d got rob=%0d exp none",
                   f, bus.o_complete_rob_rows[f].ROBNumber);
        end else begin
          e = bcx_q.pop_front();
          if (e.lane != f ||
              bus.o_complete_rob_rows[f].ROBNumber !== rob_idx'(e.idx) ||
              bus.o_complete_rob_rows[f].data !== m_data[e.idx] ||
              bus.o_complete_rob_rows[f].PRegAddrDst !== m_dst[e.idx] ||
              bus.o_complete_rob_rows[f].complete !== 1'b1) begin
            n_err++;
            $display("FAIL bcast_row lane=%0d got rob=%0d data=%0h exp lane=%0d rob=%0d data=%0h",
                     f, bus.o_complete_rob_rows[f].ROBNumber,
                     bus.o_complete_rob_rows[f].data,
                     e.lane, e.idx, m_data[e.idx]);
          end
        end
      end
    end
  end

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if (bus.o_count !== 5'd0 || bus.o_full !== 1'b0 ||
        bus.o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_flags got cnt=%0d full=%b rdy=%b exp 0 0 1",
               bus.o_count, bus.o_full, bus.o_ready);
    end
    n_chk++;
    if (bus.o_overflow !== 1'b0 || bus.o_seq_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sticky got ovf=%b seq=%b exp 0 0",
               bus.o_overflow, bus.o_seq_err);
    end
    for (int f = 0; f < ROB_NUM_FU; f++) begin
      n_chk++;
      if (bus.o_complete_rob_rows[f] !== '0) begin
        n_err++;
        $display("FAIL reset_bcast lane=%0d got %h exp 0",
                 f, bus.o_complete_rob_rows[f]);
      end
    end
    for (int l = 0; l < ROB_RETIRE_W; l++) begin
      n_chk++;
      if (bus.o_retire_rows[l] !== '0) begin
        n_err++;
        $display("FAIL reset_retire lane=%0d got %h exp 0",
                 l, bus.o_retire_rows[l]);
      end
    end
  endtask

  task automatic test_basic();
    apply_reset();
    alloc(0, 0, 5, 1'b0);
    alloc(1, 1, 6, 1'b0);
    tick();
    clr_in();
    n_chk++;
    if (bus.o_count !== 5'd2) begin
      n_err++;
      $display("FAIL basic_count got %0d exp 2", bus.o_count);
    end
    fu(0, 0, 32'hAA);
    fu(1, 1, 32'hBB);
    tick();
    clr_in();
    n_chk++;
    if (bus.o_complete_rob_rows[0].valid !== 1'b1 ||
        bus.o_complete_rob_rows[0].data !== 32'hAA ||
        bus.o_complete_rob_rows[1].valid !== 1'b1 ||
        bus.o_complete_rob_rows[1].data !== 32'hBB) begin
      n_err++;
      $display("FAIL basic_bcast got v=%b%b d0=%0h d1=%0h exp v=11 aa bb",
               bus.o_complete_rob_rows[0].valid,
               bus.o_complete_rob_rows[1].valid,
               bus.o_complete_rob_rows[0].data,
               bus.o_complete_rob_rows[1].data);
    end
    n_chk++;
    if (bus.o_retire_rows[0].valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_early_retire got 1 exp 0");
    end
    tick();
    n_chk++;
    if (bus.o_retire_rows[0].valid !== 1'b1 ||
        bus.o_retire_rows[0].PRegAddrDst !== 6'd5 ||
        bus.o_retire_rows[0].data !== 32'hAA ||
        bus.o_retire_rows[1].valid !== 1'b1 ||
        bus.o_retire_rows[1].PRegAddrDst !== 6'd6 ||
        bus.o_retire_rows[1].data !== 32'hBB) begin
      n_err++;
      $display("FAIL basic_retire got dst=%0d/%0d data=%0h/%0h exp 5/6 aa/bb",
               bus.o_retire_rows[0].PRegAddrDst,
               bus.o_retire_rows[1].PRegAddrDst,
               bus.o_retire_rows[0].data,
               bus.o_retire_rows[1].data);
    end
    n_chk++;
    if (bus.o_count !== 5'd0) begin
      n_err++;
      $display("FAIL basic_drain got %0d exp 0", bus.o_count);
    end
  endtask

  task automatic test_out_of_order();
    apply_reset();
    alloc(0, 0, 1, 1'b0);
    alloc(1, 1, 2, 1'b0);
    tick();
    clr_in();
    alloc(0, 2, 3, 1'b0);
    tick();
    clr_in();
    fu(0, 2, 32'h22);
    tick();
    clr_in();
    fu(0, 1, 32'h11);
    tick();
    clr_in();
    n_chk++;
    if (bus.o_retire_rows[0].valid !== 1'b0) begin
      n_err++;
      $display("FAIL ooo_hold1 got retire exp none");
    end
    fu(0, 0, 32'h10);
    tick();
    clr_in();
    n_chk++;
    if (bus.o_retire_rows[0].valid !== 1'b0 || bus.o_count !== 5'd3) begin
      n_err++;
      $display("FAIL ooo_hold2 got v=%b cnt=%0d exp 0 3",
               bus.o_retire_rows[0].valid, bus.o_count);
    end
    tick();
    n_chk++;
    if (bus.o_retire_rows[0].valid !== 1'b1 ||
        bus.o_retire_rows[1].valid !== 1'b1 ||
        bus.o_retire_rows[1].ROBNumber !== 4'd1 ||
        bus.o_count !== 5'd1) begin
      n_err++;
      $display("FAIL ooo_pair got v=%b%b cnt=%0d exp 11 1",
               bus.o_retire_rows[0].valid,
               bus.o_retire_rows[1].valid, bus.o_count);
    end
    tick();
    n_chk++;
    if (bus.o_retire_rows[0].valid !== 1'b1 ||
        bus.o_retire_rows[0].ROBNumber !== 4'd2 ||
        bus.o_retire_rows[1].valid !== 1'b0 ||
        bus.o_count !== 5'd0) begin
      n_err++;
      $display("FAIL ooo_last got rob=%0d v1=%b cnt=%0d exp 2 0 0",
               bus.o_retire_rows[0].ROBNumber,
               bus.o_retire_rows[1].valid, bus.o_count);
    end
  endtask

  task automatic test_full_wrap();
    bit ok;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      alloc(0, 2 * i, 10 + 2 * i, 1'b0);
      alloc(1, 2 * i + 1, 11 + 2 * i, 1'b0);
      tick();
      clr_in();
      if (i == 6) begin
        n_chk++;
        if (bus.o_count !== 5'd14 || bus.o_ready !== 1'b1 ||
            bus.o_full !== 1'b0) begin
          n_err++;
          $display("FAIL full_14 got cnt=%0d rdy=%b full=%b exp 14 1 0",
                   bus.o_count, bus.o_ready, bus.o_full);
        end
      end
    end
    n_chk++;
    if (bus.o_count !== 5'd16 || bus.o_full !== 1'b1 ||
        bus.o_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_16 got cnt=%0d full=%b rdy=%b exp 16 1 0",
               bus.o_count, bus.o_full, bus.o_ready);
    end
    set_alloc(0, 0, 50, 1'b0);
    set_alloc(1, 1, 51, 1'b0);
    tick();
    clr_in();
    n_chk++;
    if (bus.o_overflow !== 1'b1 || bus.o_count !== 5'd16 ||
        bus.o_seq_err !== 1'b0) begin
      n_err++;
      $display("FAIL full_ovf got ovf=%b cnt=%0d seq=%b exp 1 16 0",
               bus.o_overflow, bus.o_count, bus.o_seq_err);
    end
    fu(0, 0, 32'hA0);
    fu(1, 1, 32'hA1);
    tick();
    clr_in();
    set_alloc(0, 0, 52, 1'b0);
    set_alloc(1, 1, 53, 1'b0);
    tick();
    clr_in();
    n_chk++;
    if (bus.o_count !== 5'd14 || bus.o_retire_rows[1].valid !== 1'b1) begin
      n_err++;
      $display("FAIL full_retire_drop got cnt=%0d v1=%b exp 14 1",
               bus.o_count, bus.o_retire_rows[1].valid);
    end
    tick();
    alloc(0, 0, 40, 1'b0);
    alloc(1, 1, 41, 1'b0);
    tick();
    clr_in();
    n_chk++;
    if (bus.o_count !== 5'd16 || bus.o_seq_err !== 1'b0 ||
        bus.o_full !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_alloc got cnt=%0d seq=%b full=%b exp 16 0 1",
               bus.o_count, bus.o_seq_err, bus.o_full);
    end
    for (int i = 2; i < 18; i += 2) begin
      fu(0, i % 16, 32'h100 + i);
      fu(1, (i + 1) % 16, 32'h101 + i);
      tick();
      clr_in();
    end
    wait_empty(ok);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL wrap_drain got cnt=%0d exp 0 within bound",
               bus.o_count);
    end
  endtask

  task automatic test_stores();
    apply_reset();
    alloc(0, 0, 7, 1'b1);
    alloc(1, 1, 8, 1'b1);
    tick();
    clr_in();
    fu(0, 0, 32'h51);
    fu(1, 1, 32'h52);
    tick();
    clr_in();
    tick();
    n_chk++;
    if (bus.o_retire_rows[0].valid !== 1'b1 ||
        bus.o_retire_rows[0].ROBNumber !== 4'd0 ||
        bus.o_retire_rows[1].valid !== 1'b0 ||
        bus.o_count !== 5'd1) begin
      n_err++;
      $display("FAIL store_one got v=%b%b cnt=%0d exp 10 1",
               bus.o_retire_rows[0].valid,
               bus.o_retire_rows[1].valid, bus.o_count);
    end
    tick();
    n_chk++;
    if (bus.o_retire_rows[0].valid !== 1'b1 ||
        bus.o_retire_rows[0].ROBNumber !== 4'd1 ||
        bus.o_count !== 5'd0) begin
      n_err++;
      $display("FAIL store_two got rob=%0d cnt=%0d exp 1 0",
               bus.o_retire_rows[0].ROBNumber, bus.o_count);
    end
  endtask

  task automatic test_duplicate();
    bit ok;
    apply_reset();
    alloc(0, 0, 1, 1'b0);
    alloc(1, 1, 2, 1'b0);
    tick();
    clr_in();
    alloc(0, 2, 3, 1'b0);
    alloc(1, 3, 4, 1'b0);
    tick();
    clr_in();
    fu(0, 3, 32'h33);
    set_fu(2, 3, 32'h99);
    tick();
    clr_in();
    n_chk++;
    if (bus.o_complete_rob_rows[0].valid !== 1'b1 ||
        bus.o_complete_rob_rows[0].data !== 32'h33 ||
        bus.o_complete_rob_rows[2].valid !== 1'b0) begin
      n_err++;
      $display("FAIL dup_lane got v0=%b d0=%0h v2=%b exp 1 33 0",
               bus.o_complete_rob_rows[0].valid,
               bus.o_complete_rob_rows[0].data,
               bus.o_complete_rob_rows[2].valid);
    end
    set_fu(1, 3, 32'h77);
    set_fu(0, 9, 32'h55);
    tick();
    clr_in();
    n_chk++;
    if (bus.o_complete_rob_rows[0].valid !== 1'b0 ||
        bus.o_complete_rob_rows[1].valid !== 1'b0 ||
        bus.o_complete_rob_rows[2].valid !== 1'b0) begin
      n_err++;
      $display("FAIL dup_ignored got v=%b%b%b exp 000",
               bus.o_complete_rob_rows[0].valid,
               bus.o_complete_rob_rows[1].valid,
               bus.o_complete_rob_rows[2].valid);
    end
    fu(0, 0, 32'h30);
    fu(1, 1, 32'h31);
    fu(2, 2, 32'h32);
    tick();
    clr_in();
    wait_empty(ok);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL dup_drain got cnt=%0d exp 0", bus.o_count);
    end
  endtask

  task automatic test_seq_err();
    bit ok;
    apply_reset();
    set_alloc(0, 5, 9, 1'b0);
    m_dst[0]  = 6'd9;
    m_mem[0]  = 1'b0;
    m_data[0] = '0;
    ret_q.push_back(0);
    tick();
    clr_in();
    n_chk++;
    if (bus.o_seq_err !== 1'b1 || bus.o_count !== 5'd1) begin
      n_err++;
      $display("FAIL seq_flag got seq=%b cnt=%0d exp 1 1",
               bus.o_seq_err, bus.o_count);
    end
    fu(0, 0, 32'h66);
    tick();
    clr_in();
    wait_empty(ok);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL seq_drain got cnt=%0d exp 0", bus.o_count);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    alloc(0, 0, 1, 1'b0);
    alloc(1, 1, 2, 1'b0);
    tick();
    clr_in();
    alloc(0, 2, 3, 1'b0);
    alloc(1, 3, 4, 1'b0);
    tick();
    clr_in();
    alloc(0, 4, 5, 1'b0);
    tick();
    clr_in();
    fu(0, 0, 32'h40);
    tick();
    clr_in();
    set_fu(0, 1, 32'h44);
    set_alloc(0, 5, 6, 1'b0);
    rst = 1'b1;
    tick();
    clr_in();
    rst = 1'b0;
    ret_q.delete();
    bcx_q.delete();
    n_chk++;
    if (bus.o_complete_rob_rows[0].valid !== 1'b0 ||
        bus.o_retire_rows[0].valid !== 1'b0 ||
        bus.o_count !== 5'd0 || bus.o_ready !== 1'b1 ||
        bus.o_full !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_state got bv=%b rv=%b cnt=%0d rdy=%b exp 0 0 0 1",
               bus.o_complete_rob_rows[0].valid,
               bus.o_retire_rows[0].valid, bus.o_count, bus.o_ready);
    end
    alloc(0, 0, 21, 1'b0);
    tick();
    clr_in();
    n_chk++;
    if (bus.o_count !== 5'd1 || bus.o_seq_err !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_alloc got cnt=%0d seq=%b exp 1 0",
               bus.o_count, bus.o_seq_err);
    end
    fu(0, 0, 32'h21);
    tick();
    clr_in();
    n_chk++;
    if (bus.o_complete_rob_rows[0].valid !== 1'b1 ||
        bus.o_complete_rob_rows[0].ROBNumber !== 4'd0 ||
        bus.o_complete_rob_rows[0].PRegAddrDst !== 6'd21) begin
      n_err++;
      $display("FAIL midrst_idx got rob=%0d dst=%0d exp 0 21",
               bus.o_complete_rob_rows[0].ROBNumber,
               bus.o_complete_rob_rows[0].PRegAddrDst);
    end
    wait_empty(ok);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL midrst_drain got cnt=%0d exp 0", bus.o_count);
    end
  endtask

  initial begin
    clr_in();
    test_reset();
    test_basic();
    test_out_of_order();
    test_full_wrap();
    test_stores();
    test_duplicate();
    test_seq_err();
    test_reset_mid();
    tick();
    tick();
    n_chk++;
    if (ret_q.size() != 0 || bcx_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover got ret=%0d bc=%0d exp 0 0",
               ret_q.size(), bcx_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
